alu_shift_seq: RTL
==================

# alu_shift_seq

Multi-cycle shift sequencer that drives the single-step `alu_shift` unit. It accepts one shift request: opcode, operand, shift amount and incoming flags. It executes the request by issuing the single-bit shift opcode once per clock and feeding each result and carry back into the unit. It then presents the final result and flags with a one-cycle done pulse. It sits between the instruction decode/issue stage and the shift unit, and turns `alu_shift` into an N-position shifter/rotator.

## Interface
Parameters:
- `data_wl`, 16, data word width.
- `op_wl`, 8, opcode width.
- `cnt_wl`, 4, shift-amount width (max amount 2^cnt_wl-1).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_in`  in  1  request strobe; accepted only when `busy_out`=0.
- `op_in`  in  op_wl  shift opcode (0x80–0x85, 0x88–0x8D).
- `b_in`  in  data_wl  operand.
- `amt_in`  in  cnt_wl  shift count.
- `c_flag_in`, `z_flag_in`, `s_flag_in`, `ovr_flag_in`  in  1 each  incoming flags.
- `sh_op_out`  out  op_wl  opcode to shift unit.
- `sh_b_out`  out  data_wl  operand to shift unit.
- `sh_c_flag_out`  out  1  carry to shift unit.
- `sh_c_in`  in  data_wl  shift unit result.
- `sh_c_flag_in`, `sh_z_flag_in`, `sh_s_flag_in`  in  1 each  shift unit flags.
- `sh_op_active_in`  in  1  shift unit opcode-recognised indication.
- `c_out`  out  data_wl  final result, held until the next accepted start.
- `z_flag_out`, `s_flag_out`, `c_flag_out`, `ovr_flag_out`  out  1 each  final flags, held.
- `busy_out`  out  1  high in any state other than IDLE.
- `done_out`  out  1  one-cycle completion pulse.
- `err_out`  out  1  high with `done_out` when the opcode was rejected.

## Operation
States: IDLE, SHIFT, DONE.

IDLE
- `start_in`=1 latches `op_in`→op_r, `b_in`→work_r, `c_flag_in`→carry_r, `ovr_flag_in`→ovr_r, and `amt_in`→cnt_r.
- If `amt_in`=0, go to DONE with result = `b_in`, z = (`b_in`==0), s = `b_in`[msb], c = `c_flag_in`, err = 0.
- Otherwise go to SHIFT.

SHIFT
- Drive `sh_op_out`=op_r, `sh_b_out`=work_r, `sh_c_flag_out`=carry_r.
- If `sh_op_active_in`=1:
  - work_r←`sh_c_in`, carry_r←`sh_c_flag_in`, z_r←`sh_z_flag_in`, s_r←`sh_s_flag_in`.
  - cnt_r←cnt_r−1.
  - If cnt_r==1, go to DONE.
- If `sh_op_active_in`=0 (invalid opcode):
  - Go to DONE with err_r=1, result 0, z=1, s=0, c=0.
  - This is detected on the first SHIFT cycle.

DONE
- `done_out`=1 and `err_out`=err_r for this cycle only.
- Go to IDLE.

General rules:
- Outside SHIFT, `sh_op_out`=0x00, `sh_b_out`=0, `sh_c_flag_out`=0. The unit then reports inactive.
- `c_out` and the flag outputs are registered. They update on the DONE entry edge and hold until the next accepted start.
- `ovr_flag_out` = ovr_r, a passthrough that no shift changes.
- Carry chains across steps: each step's `sh_c_flag_in` becomes the next step's `sh_c_flag_out`. This is required for correct SHRC, SHLC, ROTRC and ROTLC.
- `start_in` is ignored while `busy_out`=1, including in the DONE cycle. It is not queued.
- No width growth: the result is always data_wl bits, and bits shifted out are lost except through the carry for the *C ops.

## Timing
- Reset values: state IDLE; `c_out`=0; all flag outputs 0; `busy_out`=0; `done_out`=0; `err_out`=0; `sh_*` outputs 0. Internal registers are 0.
- Reset mid-operation aborts immediately. No `done_out` is issued for the aborted request.
- Start accepted at edge E0. SHIFT then occupies cycles 1..N, where N=`amt_in`. `done_out` is high in cycle N+1.
- Latency by case:
  - `amt_in`=0: done in cycle 1.
  - Invalid opcode: done in cycle 2.
  - Maximum: 2^cnt_wl cycles.
- Back-to-back throughput: one request per N+2 cycles. The earliest next start is the cycle after DONE.
- The shift unit is combinational. Its result is captured on the same edge that ends each SHIFT cycle.

## Test plan
1. SHL0 (0x88), b=0x0001, amt=4, c=0 → `c_out`=0x0010, z=0, s=0, c=0. `done_out` in cycle 5, `busy_out` high in cycles 1–5.
2. ROTRC (0x85), b=0x0003, amt=2, c=0 → intermediate 0x0001/c=1. Final `c_out`=0x8000, c=1, s=1, z=0.
3. SHRA (0x82), b=0x8000, amt=15 → `c_out`=0xFFFF, s=1, z=0. `done_out` in cycle 16. A `start_in` pulsed in cycle 7 is ignored.
4. amt=0, b=0x0000, c=1, ovr=1 → `c_out`=0x0000, z=1, c=1, ovr=1. `done_out` in cycle 1, err=0.
5. op=0x42, b=0x1234, amt=3 → `err_out`=`done_out`=1 in cycle 2. `c_out`=0, z=1, s=0, c=0.
6. SHL1 (0x89), amt=8, `rst` asserted in cycle 3 → next cycle: IDLE, `busy_out`=0, `c_out`=0, all flags 0, no `done_out`. Then ROTL (0x8C), b=0x8001, amt=1 → `c_out`=0x0003, done in cycle 2.

Source files
------------

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift sequencer: repeats a single-bit alu_shift opcode N times,
// chaining result and carry back through the combinational shift unit.
module alu_shift_seq #(
  parameter int data_wl = 16,
  parameter int op_wl   = 8,
  parameter int cnt_wl  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_in,
  input  logic [op_wl-1:0]   op_in,
  input  logic [data_wl-1:0] b_in,
  input  logic [cnt_wl-1:0]  amt_in,
  input  logic               c_flag_in,
  input  logic               z_flag_in,
  input  logic               s_flag_in,
  input  logic               ovr_flag_in,
  output logic [op_wl-1:0]   sh_op_out,
  output logic [data_wl-1:0] sh_b_out,
  output logic               sh_c_flag_out,
  input  logic [data_wl-1:0] sh_c_in,
  input  logic               sh_c_flag_in,
  input  logic               sh_z_flag_in,
  input  logic               sh_s_flag_in,
  input  logic               sh_op_active_in,
  output logic [data_wl-1:0] c_out,
  output logic               z_flag_out,
  output logic               s_flag_out,
  output logic               c_flag_out,
  output logic               ovr_flag_out,
  output logic               busy_out,
  output logic               done_out,
  output logic               err_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [op_wl-1:0]     op_q, op_d;
  logic [data_wl-1:0]   work_q, work_d;
  logic                 carry_q, carry_d;
  logic                 ovr_q, ovr_d;
  logic [cnt_wl-1:0]    cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [data_wl-1:0]   res_q, res_d;
  logic                 zo_q, zo_d;
  logic                 so_q, so_d;
  logic                 co_q, co_d;

  // Incoming z/s are superseded by the result; kept on the port for decode symmetry.
  logic unused_flags;
  assign unused_flags = z_flag_in ^ s_flag_in;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    work_d        = work_q;
    carry_d       = carry_q;
    ovr_d         = ovr_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    res_d         = res_q;
    zo_d          = zo_q;
    so_d          = so_q;
    co_d          = co_q;
    sh_op_out     = '0;
    sh_b_out      = '0;
    sh_c_flag_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          op_d    = op_in;
          work_d  = b_in;
          carry_d = c_flag_in;
          ovr_d   = ovr_flag_in;
          cnt_d   = amt_in;
          err_d   = 1'b0;
          if (amt_in == '0) begin
            state_d = DONE;
            res_d   = b_in;
            zo_d    = (b_in == '0);
            so_d    = b_in[data_wl-1];
            co_d    = c_flag_in;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        sh_op_out     = op_q;
        sh_b_out      = work_q;
        sh_c_flag_out = carry_q;
        if (sh_op_active_in) begin
          work_d  = sh_c_in;
          carry_d = sh_c_flag_in;
          cnt_d   = cnt_q - cnt_wl'(1);
          if (cnt_q == cnt_wl'(1)) begin
            state_d = DONE;
            res_d   = sh_c_in;
            zo_d    = sh_z_flag_in;
            so_d    = sh_s_flag_in;
            co_d    = sh_c_flag_in;
          end
        end else begin
          // Unit rejected the opcode; only the first step can see this.
          state_d = DONE;
          err_d   = 1'b1;
          res_d   = '0;
          zo_d    = 1'b1;
          so_d    = 1'b0;
          co_d    = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
      zo_q    <= 1'b0;
      so_q    <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      res_q   <= res_d;
      zo_q    <= zo_d;
      so_q    <= so_d;
      co_q    <= co_d;
    end
  end

  assign c_out        = res_q;
  assign z_flag_out   = zo_q;
  assign s_flag_out   = so_q;
  assign c_flag_out   = co_q;
  assign ovr_flag_out = ovr_q;
  assign busy_out     = (state_q != IDLE);
  assign done_out     = (state_q == DONE);
  assign err_out      = (state_q == DONE) & err_q;

endmodule
